mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 32-bit memory/bus port between 4 requesters.
//  Requesters are IF fetch, MEM load/store, debug and spare.
//  Drives the 2-bit select of the 4:1 32-bit datapath mux in front of the port.
//  Sequences each transaction with a valid/ready handshake, a timeout and bounded locked bursts.
//  Sits between the pipeline stage request logic and the shared memory interface.
// PARAMETERS
//  TIMEOUT_CYCLES  16  BUSY cycles without mem_ready_i before abort (>=1)
//  LOCK_MAX        4   max consecutive beats one locked requester may hold the port (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_i        in   4   per-requester request, held high until its ack_o
//  lock_i       in   4   per-requester "keep port for next beat" hint, sampled at completion
//  mem_ready_i  in   1   memory completes current beat this cycle
//  gnt_o        out  4   one-hot grant (registered); all-zero when idle
//  sel_o        out  2   mux select = index of granted requester (registered)
//  mem_valid_o  out  1   beat in progress toward memory
//  ack_o        out  4   one-hot completion pulse, = gnt_o & {4{mem_ready_i | timeout}}
//  err_o        out  4   one-hot timeout pulse, coincident with the matching ack_o bit
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE.
//   - Outputs: gnt_o=0, sel_o=0, mem_valid_o=0, ack_o=0, err_o=0.
//   - Counters: timeout=0, beat=0. last_ptr=3, so requester 0 has top priority first.
//  States: IDLE, BUSY.
//  IDLE:
//   - If req_i==0, stay in IDLE.
//   - Otherwise pick the first set req_i bit, searching last_ptr+1, +2, +3, +4 mod 4.
//   - Next cycle: BUSY; gnt_o one-hot(g); sel_o=g; mem_valid_o=1; timeout=0; beat=1.
//   - Latency from req_i to gnt_o: 1 cycle. Idle-to-busy bubble is accepted.
//  BUSY:
//   - gnt_o, sel_o and mem_valid_o are stable.
//   - The timeout counter increments every cycle in which mem_ready_i=0.
//   - Completion: mem_ready_i=1 -> ack_o[g]=1 in the same cycle (combinational). last_ptr<=g.
//   - Locked continuation: if lock_i[g]&&req_i[g]&&beat<LOCK_MAX at completion ->
//     stay BUSY, grant unchanged, beat<=beat+1, timeout<=0.
//     For continuation the requester keeps req_i high after ack.
//   - Otherwise -> IDLE; gnt_o, sel_o and mem_valid_o clear on the next edge.
//     The requester must drop req_i in the cycle after ack, or it is seen as a new request.
//   - Timeout: timeout==TIMEOUT_CYCLES-1 && !mem_ready_i -> ack_o[g]=1, err_o[g]=1 this cycle.
//     Then -> IDLE, last_ptr<=g. A lock is ignored on timeout.
//   - mem_ready_i and timeout in the same cycle: ready wins, no err_o.
//  Fairness:
//   - With all requesters active and no lock, grant order is 0,1,2,3,0,...
//   - A locked requester holds the port for at most LOCK_MAX beats.
//     Then the pointer rotates past it.
//  Ignored inputs:
//   - req_i changes during BUSY do not affect the current grant.
//   - Dropping req_i[g] mid-beat is illegal; ack is still issued.
//  Reset mid-transaction: the beat is abandoned silently. No ack_o or err_o is produced.
//  Widths:
//   - timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, saturates, never wraps.
//   - beat counter is $clog2(LOCK_MAX+1) bits.
// STRUCTURE
//  Shared package: state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1), NUM_REQ=4, SEL_W=2.
//  Also in the package: requester index constants REQ_IF=0, REQ_MEM=1, REQ_DBG=2, REQ_SPARE=3.
//  One sub-module: rr_pick4 (combinational).
//   - Inputs: req[3:0], last_ptr[1:0].
//   - Outputs: any, idx[1:0].
//  FSM, counters and output registers live in the top.
// TESTING
//  1 Reset: assert rst_n=0 mid-BUSY -> gnt_o=0, sel_o=0, mem_valid_o=0, ack_o=0 same cycle.
//  2 Single: req_i=4'b0100, ready 3 cycles after grant.
//    -> gnt_o=0100 and sel_o=2 one cycle after req. ack_o=0100 on the ready cycle.
//    -> gnt_o=0 the cycle after.
//  3 Round robin: req_i=4'b1111 held, mem_ready_i=1, each requester re-requests after ack.
//    -> sel_o sequence 0,1,2,3,0.
//  4 Timeout: req_i=4'b0010, mem_ready_i=0. On the 16th BUSY cycle ack_o=err_o=0010.
//    Then IDLE. Variant with ready on that same cycle -> err_o=0.
//  5 Lock: req_i=4'b0011, lock_i[0]=1, ready every cycle.
//    -> 4 consecutive beats to 0, then sel_o=1.
//  6 Edge: ready asserted in the grant cycle -> 1-cycle beat.
//    Request arriving during BUSY waits; the next grant follows rotation from last_ptr.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the 4-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  // Requester indices
  localparam logic [SEL_W-1:0] REQ_IF    = SEL_W'(0);
  localparam logic [SEL_W-1:0] REQ_MEM   = SEL_W'(1);
  localparam logic [SEL_W-1:0] REQ_DBG   = SEL_W'(2);
  localparam logic [SEL_W-1:0] REQ_SPARE = SEL_W'(3);

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after last_ptr, wrapping.
module rr_pick4
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Search last_ptr+1 .. last_ptr+4 (mod 4); the last candidate is last_ptr itself.
  always_comb begin
    any   = |req;
    idx   = last_ptr;
    found = 1'b0;
    cand  = last_ptr;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between IF, MEM, debug and spare
// requesters, with valid/ready handshake, beat timeout and bounded locked bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned LOCK_MAX       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic               mem_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               mem_valid_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [NUM_REQ-1:0] err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(LOCK_MAX + 1);

  state_t             state, state_nx;
  logic [TW-1:0]      tcnt;
  logic [BW-1:0]      beat;
  logic [SEL_W-1:0]   last_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               valid;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               busy, timeout_hit, done, cont;

  rr_pick4 u_pick (
    .req      (req_i),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Beat completion, timeout and locked-continuation decode.
  always_comb begin
    busy        = (state == ST_BUSY);
    timeout_hit = busy && !mem_ready_i && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    done        = busy && (mem_ready_i || timeout_hit);
    // Lock is only honoured on a real ready; a timed-out beat always releases.
    cont        = busy && mem_ready_i && lock_i[sel] && req_i[sel]
                  && (beat < BW'(LOCK_MAX));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (pick_any)      state_nx = ST_BUSY;
      ST_BUSY: if (done && !cont) state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  // Grant registers, rotation pointer, beat and timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      tcnt     <= '0;
      beat     <= '0;
      last_ptr <= REQ_SPARE;
    end else if (state == ST_IDLE) begin
      if (pick_any) begin
        gnt   <= onehot(pick_idx);
        sel   <= pick_idx;
        valid <= 1'b1;
        tcnt  <= '0;
        beat  <= BW'(1);
      end
    end else if (done) begin
      last_ptr <= sel;
      if (cont) begin
        beat <= beat + 1'b1;
        tcnt <= '0;
      end else begin
        gnt   <= '0;
        sel   <= '0;
        valid <= 1'b0;
      end
    end else if (tcnt != '1) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Registered grant outputs plus combinational completion pulses.
  always_comb begin
    gnt_o       = gnt;
    sel_o       = sel;
    mem_valid_o = valid;
    ack_o       = gnt & {NUM_REQ{done}};
    err_o       = gnt & {NUM_REQ{timeout_hit}};
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 16;
  localparam int LM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i, lock_i;
  logic       mem_ready_i;
  logic [3:0] gnt_o, ack_o, err_o;
  logic [1:0] sel_o;
  logic       mem_valid_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: who owns the port, rotation pointer, stall cycles and beats.
  bit m_busy;
  int m_g, m_last, m_wait, m_beat;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .LOCK_MAX       (LM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .mem_ready_i (mem_ready_i),
    .gnt_o       (gnt_o),
    .sel_o       (sel_o),
    .mem_valid_o (mem_valid_o),
    .ack_o       (ack_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_last = 3; m_wait = 0; m_beat = 0;
  endtask

  // Compare all outputs with what the model predicts for the current inputs.
  task automatic model_check();
    logic [3:0] e_gnt, e_ack, e_err;
    bit         tmo;
    e_gnt = m_busy ? 4'(1 << m_g) : 4'b0;
    tmo   = m_busy && !mem_ready_i && (m_wait == TO - 1);
    e_ack = (m_busy && (mem_ready_i || tmo)) ? e_gnt : 4'b0;
    e_err = tmo ? e_gnt : 4'b0;
    chk("gnt",   gnt_o, e_gnt);
    chk("sel",   {2'b00, sel_o}, m_busy ? 4'(m_g) : 4'd0);
    chk("valid", {3'b000, mem_valid_o}, {3'b000, m_busy});
    chk("ack",   ack_o, e_ack);
    chk("err",   err_o, e_err);
  endtask

  // Advance the model by one clock using the inputs seen at the edge.
  task automatic model_update();
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (req_i[c]) begin
          m_busy = 1; m_g = c; m_wait = 0; m_beat = 1;
          break;
        end
      end
    end else if (mem_ready_i) begin
      m_last = m_g;
      if (lock_i[m_g] && req_i[m_g] && m_beat < LM) begin
        m_beat++; m_wait = 0;
      end else begin
        m_busy = 0;
      end
    end else if (m_wait == TO - 1) begin
      m_last = m_g;
      m_busy = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; lock_i = '0; mem_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int q[$];
    bit stall;

    // 1: reset state, then reset asserted mid-beat
    do_reset();
    cycle();
    req_i = 4'b0001;
    cycle();
    at_neg();
    chk("t1_busy_before_reset", {3'b000, mem_valid_o}, 4'b0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0; mem_ready_i = 1'b1;
    #1;
    model_reset();
    chk("t1_rst_gnt",   gnt_o, 4'b0000);
    chk("t1_rst_sel",   {2'b00, sel_o}, 4'd0);
    chk("t1_rst_valid", {3'b000, mem_valid_o}, 4'd0);
    chk("t1_rst_ack",   ack_o, 4'b0000);
    chk("t1_rst_err",   err_o, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1; req_i = '0; mem_ready_i = 1'b0;

    // 2: single request from debug, ready 3 cycles after grant
    req_i = 4'b0100;
    cycle();
    at_neg();
    chk("t2_gnt", gnt_o, 4'b0100);
    chk("t2_sel", {2'b00, sel_o}, 4'd2);
    at_pos();
    cycle(); cycle();
    mem_ready_i = 1'b1;
    at_neg();
    chk("t2_ack", ack_o, 4'b0100);
    at_pos();
    req_i = '0; mem_ready_i = 1'b0;
    at_neg();
    chk("t2_gnt_after", gnt_o, 4'b0000);
    at_pos();

    // 3: round robin with everyone requesting, no lock
    do_reset();
    req_i = 4'b1111; mem_ready_i = 1'b1;
    q = {};
    for (int i = 0; i < 12; i++) begin
      at_neg();
      if (mem_valid_o) q.push_back(int'(sel_o));
      at_pos();
    end
    for (int i = 0; i < 5; i++)
      chk("t3_rr_order", (i < q.size()) ? 4'(q[i]) : 4'hF, 4'(i % 4));

    // 4: timeout on the 16th BUSY cycle, then variant where ready wins
    do_reset();
    req_i = 4'b0010;
    cycle();
    for (int i = 1; i <= TO; i++) begin
      at_neg();
      if (i == TO) begin
        chk("t4_tmo_ack", ack_o, 4'b0010);
        chk("t4_tmo_err", err_o, 4'b0010);
      end else begin
        chk("t4_no_err", err_o, 4'b0000);
      end
      at_pos();
    end
    req_i = '0;
    at_neg();
    chk("t4_idle", {3'b000, mem_valid_o}, 4'd0);
    at_pos();
    req_i = 4'b0010;
    cycle();
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) mem_ready_i = 1'b1;
      at_neg();
      if (i == TO) begin
        chk("t4v_ack", ack_o, 4'b0010);
        chk("t4v_err", err_o, 4'b0000);
      end
      at_pos();
    end
    req_i = '0; mem_ready_i = 1'b0;
    cycle();

    // 5: locked burst capped at LOCK_MAX beats
    do_reset();
    req_i = 4'b0011; lock_i = 4'b0001; mem_ready_i = 1'b1;
    q = {};
    for (int i = 0; i < 8; i++) begin
      at_neg();
      if (mem_valid_o) q.push_back(int'(sel_o));
      at_pos();
    end
    for (int i = 0; i < 5; i++)
      chk("t5_lock_seq", (i < q.size()) ? 4'(q[i]) : 4'hF, (i < LM) ? 4'd0 : 4'd1);
    lock_i = '0;

    // 6: ready in the grant cycle; request arriving mid-beat waits its turn
    do_reset();
    req_i = 4'b0001; mem_ready_i = 1'b1;
    cycle();
    at_neg();
    chk("t6_one_cycle_ack", ack_o, 4'b0001);
    at_pos();
    req_i = '0; mem_ready_i = 1'b0;
    cycle();
    req_i = 4'b0001;
    cycle();
    req_i = 4'b0101;
    cycle(); cycle();
    mem_ready_i = 1'b1;
    cycle();
    req_i = 4'b0100; mem_ready_i = 1'b0;
    cycle();
    at_neg();
    chk("t6_next_sel", {2'b00, sel_o}, 4'd2);
    at_pos();
    req_i = '0; mem_ready_i = 1'b1;
    cycle();
    mem_ready_i = 1'b0;

    // Random traffic, with stall phases long enough to reach timeouts
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) stall = ~stall;
      req_i       = 4'($urandom);
      lock_i      = 4'($urandom);
      mem_ready_i = stall ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
